// File: rtl/mem_packet_pkg.sv
// Shared memory-packet layout and responder state encoding.
// Packet packing is {type, write, valid, data, addr} with addr at the LSBs.
`timescale 1ns/1ps
package mem_packet_pkg;

    localparam int MP_ADDR_WIDTH   = 32;
    localparam int MP_BLOCK_BITS   = 512;
    localparam int MP_TYPE_WIDTH   = 3;
    localparam int MP_PACKET_WIDTH = MP_ADDR_WIDTH + MP_BLOCK_BITS + 2 + MP_TYPE_WIDTH;

    localparam int ADDR_POS_LO = 0;
    localparam int ADDR_POS_HI = MP_ADDR_WIDTH - 1;
    localparam int DATA_POS_LO = MP_ADDR_WIDTH;
    localparam int DATA_POS_HI = MP_ADDR_WIDTH + MP_BLOCK_BITS - 1;
    localparam int VALID_POS   = DATA_POS_HI + 1;
    localparam int WRITE_POS   = VALID_POS + 1;
    localparam int TYPE_POS_LO = WRITE_POS + 1;
    localparam int TYPE_POS_HI = TYPE_POS_LO + MP_TYPE_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCEPT  = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/mem_packet_responder_if.sv
// Request/response packet bus between the cache (master) and a memory responder (slave).
`timescale 1ns/1ps
interface mem_packet_responder_if #(
    parameter int W = mem_packet_pkg::MP_PACKET_WIDTH
);
    logic [W-1:0] request_packet_in;
    logic         request_packet_ack_out;
    logic [W-1:0] response_packet_out;
    logic         response_packet_ack_in;

    modport slave (
        input  request_packet_in,
        input  response_packet_ack_in,
        output request_packet_ack_out,
        output response_packet_out
    );

    modport master (
        output request_packet_in,
        output response_packet_ack_in,
        input  request_packet_ack_out,
        input  response_packet_out
    );
endinterface

// File: rtl/mem_responder_storage.sv
// Block-wide backing array: one synchronous write port, one combinational read port,
// whole array cleared asynchronously on reset_in.
`timescale 1ns/1ps
module mem_responder_storage #(
    parameter int NUM_BLOCKS         = 32,
    parameter int BLOCK_SIZE_IN_BITS = 512
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic                          i_wr_en,
    input  logic [$clog2(NUM_BLOCKS)-1:0] i_wr_index,
    input  logic [BLOCK_SIZE_IN_BITS-1:0] i_wr_data,
    input  logic [$clog2(NUM_BLOCKS)-1:0] i_rd_index,
    output logic [BLOCK_SIZE_IN_BITS-1:0] o_rd_data
);

    logic [BLOCK_SIZE_IN_BITS-1:0] r_mem [NUM_BLOCKS];

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_index];

endmodule

// File: rtl/mem_packet_responder.sv
// Memory-side responder for the cache's memory packet port: block read/write with
// programmable latency. Define MEM_PACKET_RESPONDER_WRITE_RESPONSE_EN to acknowledge writes.
//
// state   | meaning
// IDLE    | waiting for a valid request; latches it and pulses ack
// ACCEPT  | ack drops, producer releasing valid; latency counter loaded
// WAIT    | counting down; at zero commits a write or samples read data
// RESPOND | response held until response_packet_ack_in
`timescale 1ns/1ps
module mem_packet_responder
    import mem_packet_pkg::*;
#(
    parameter int ADDR_WIDTH               = MP_ADDR_WIDTH,
    parameter int BLOCK_SIZE_IN_BITS       = MP_BLOCK_BITS,
    parameter int TYPE_WIDTH               = MP_TYPE_WIDTH,
    parameter int MEM_PACKET_WIDTH_IN_BITS = ADDR_WIDTH + BLOCK_SIZE_IN_BITS + 2 + TYPE_WIDTH,
    parameter int NUM_BLOCKS               = 32,
    parameter int LATENCY                  = 4
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    mem_packet_responder_if.slave  bus
);

    localparam int OFF_BITS = $clog2(BLOCK_SIZE_IN_BITS / 8);
    localparam int IDX_W    = $clog2(NUM_BLOCKS);
    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                        r_state;
    logic [TYPE_WIDTH-1:0]         r_type;
    logic                          r_write;
    logic [BLOCK_SIZE_IN_BITS-1:0] r_data;
    logic [ADDR_WIDTH-1:0]         r_addr;
    logic [CNT_W-1:0]              r_count;
    logic                          r_ack;
    logic [MEM_PACKET_WIDTH_IN_BITS-1:0] r_resp;

    logic [IDX_W-1:0]              w_index;
    logic [BLOCK_SIZE_IN_BITS-1:0] w_rd_data;
    logic                          w_wr_en;
    logic                          w_req_valid;

    // Upper address bits above the index are dropped, so blocks alias modulo NUM_BLOCKS.
    assign w_index     = r_addr[OFF_BITS +: IDX_W];
    assign w_req_valid = bus.request_packet_in[VALID_POS];
    assign w_wr_en     = (r_state == WAIT) && (r_count == '0) && r_write;

    mem_responder_storage #(
        .NUM_BLOCKS         (NUM_BLOCKS),
        .BLOCK_SIZE_IN_BITS (BLOCK_SIZE_IN_BITS)
    ) u_storage (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_index),
        .i_wr_data  (r_data),
        .i_rd_index (w_index),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= IDLE;
            r_type  <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_resp  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_valid) begin
                        r_type  <= bus.request_packet_in[TYPE_POS_HI:TYPE_POS_LO];
                        r_write <= bus.request_packet_in[WRITE_POS];
                        r_data  <= bus.request_packet_in[DATA_POS_HI:DATA_POS_LO];
                        r_addr  <= bus.request_packet_in[ADDR_POS_HI:ADDR_POS_LO];
                        r_ack   <= 1'b1;
                        r_state <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    r_ack   <= 1'b0;
                    r_count <= CNT_W'(LATENCY - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_count == '0) begin
                        if (r_write) begin
`ifdef MEM_PACKET_RESPONDER_WRITE_RESPONSE_EN
                            r_resp  <= {r_type, 1'b1, 1'b1, r_data, r_addr};
                            r_state <= RESPOND;
`else
                            r_state <= IDLE;
`endif
                        end else begin
                            r_resp  <= {r_type, 1'b0, 1'b1, w_rd_data, r_addr};
                            r_state <= RESPOND;
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                RESPOND: begin
                    if (bus.response_packet_ack_in) begin
                        r_resp  <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.request_packet_ack_out = r_ack;
    assign bus.response_packet_out    = r_resp;

endmodule
